// File: rtl/qalu_arbiter.sv
// qalu_arbiter: two-requester round-robin sequencer for one shared combinational quaternary ALU
// Optional operand/opcode legality check is enabled by defining QALU_ARB_OPCHECK_EN.
module qalu_arbiter #(
    parameter int W      = 7,
    parameter int OPW    = 4,
    parameter int MAX_OP = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [W-1:0]   req0_a,
    input  logic [W-1:0]   req0_b,
    input  logic [OPW-1:0] req0_op,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [W-1:0]   req1_a,
    input  logic [W-1:0]   req1_b,
    input  logic [OPW-1:0] req1_op,
    output logic           resp0_valid,
    input  logic           resp0_ready,
    output logic [W-1:0]   resp0_data,
    output logic           resp0_carry,
    output logic           resp0_err,
    output logic           resp1_valid,
    input  logic           resp1_ready,
    output logic [W-1:0]   resp1_data,
    output logic           resp1_carry,
    output logic           resp1_err,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic [OPW-1:0] alu_sel,
    input  logic [W-1:0]   alu_out,
    input  logic           alu_carry
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t state;
    logic last_grant, owner, gnt, accept, bad, ill, res_carry, res_err;
    logic [W-1:0] res_data, sel_a, sel_b;
    logic [OPW-1:0] sel_op;
`ifdef QALU_ARB_OPCHECK_EN
    localparam bit OPCHECK = 1'b1;
`else
    localparam bit OPCHECK = 1'b0;
`endif
    function automatic logic digits_ok(input logic [W-1:0] v);
        return (v % W'(10)) <= W'(3) && (v / W'(10)) <= W'(3);
    endfunction
    // Under contention the requester not served last wins; a lone requester always wins.
    assign gnt        = (req0_valid && req1_valid) ? !last_grant : req1_valid;
    assign req0_ready = !rst && state == IDLE && req0_valid && !gnt;
    assign req1_ready = !rst && state == IDLE && req1_valid && gnt;
    assign accept     = req0_ready || req1_ready;
    assign sel_a      = gnt ? req1_a : req0_a;
    assign sel_b      = gnt ? req1_b : req0_b;
    assign sel_op     = gnt ? req1_op : req0_op;
    assign bad        = OPCHECK && !(sel_op <= OPW'(MAX_OP) && digits_ok(sel_a) && digits_ok(sel_b));
    // One result register serves both requesters; only the owner's valid is raised.
    assign resp0_data  = res_data;
    assign resp1_data  = res_data;
    assign resp0_carry = res_carry;
    assign resp1_carry = res_carry;
    assign resp0_err   = res_err;
    assign resp1_err   = res_err;
    // Accept, let the ALU settle for one cycle on registered operands, then hold the result until consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            owner       <= 1'b0;
            ill         <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_sel     <= '0;
            res_data    <= '0;
            res_carry   <= 1'b0;
            res_err     <= 1'b0;
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    owner      <= gnt;
                    last_grant <= gnt;
                    alu_a      <= sel_a;
                    alu_b      <= sel_b;
                    alu_sel    <= sel_op;
                    ill        <= bad;
                    state      <= EXEC;
                end
                EXEC: begin
                    res_data    <= ill ? '0 : alu_out;
                    res_carry   <= !ill && alu_sel == '0 && alu_carry;
                    res_err     <= ill;
                    resp0_valid <= !owner;
                    resp1_valid <= owner;
                    state       <= RESP;
                end
                RESP: if (owner ? resp1_ready : resp0_ready) begin
                    resp0_valid <= 1'b0;
                    resp1_valid <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_qalu_arbiter.sv
// tb_qalu_arbiter: self-checking bench with a behavioural quaternary ALU and reference model
module tb_qalu_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic req0_valid, req0_ready, req1_valid, req1_ready;
    logic [6:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0] req0_op, req1_op;
    logic resp0_valid, resp0_ready, resp0_carry, resp0_err;
    logic resp1_valid, resp1_ready, resp1_carry, resp1_err;
    logic [6:0] resp0_data, resp1_data, alu_a, alu_b, alu_out;
    logic [3:0] alu_sel;
    logic alu_carry;
    int passed = 0;
    int total = 0;

    qalu_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data),
        .resp0_carry(resp0_carry), .resp0_err(resp0_err),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data),
        .resp1_carry(resp1_carry), .resp1_err(resp1_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out), .alu_carry(alu_carry)
    );

    always #5 clk = ~clk;

    function automatic int q2n(input logic [6:0] v);
        return (int'(v) / 10) * 4 + int'(v) % 10;
    endfunction

    function automatic logic [6:0] n2q(input int n);
        return 7'((n / 4) * 10 + n % 4);
    endfunction

    // Quaternary ALU: returns {carry, result}; sub/shift also raise carry so masking is observable.
    function automatic logic [7:0] qalu(input logic [6:0] a, input logic [6:0] b, input logic [3:0] op);
        int na, nb, r;
        logic c;
        na = q2n(a);
        nb = q2n(b);
        c = 1'b0;
        case (op)
            4'd0: begin r = na + nb; c = r > 15; end
            4'd1: begin r = na - nb; c = r < 0; end
            4'd2: begin r = na * 2; c = r > 15; end
            4'd3: begin r = na / 2; c = na % 2 == 1; end
            4'd4: r = (na > nb) ? 1 : 0;
            default: r = 0;
        endcase
        return {c, n2q(r & 15)};
    endfunction

    always_comb {alu_carry, alu_out} = qalu(alu_a, alu_b, alu_sel);

    function automatic bit legal(input int a, input int b, input int op);
        return op <= 4 && a % 10 <= 3 && a / 10 <= 3 && b % 10 <= 3 && b / 10 <= 3;
    endfunction

    task automatic model(input logic [6:0] a, input logic [6:0] b, input logic [3:0] op,
                         output logic [6:0] d, output logic c, output logic e);
        logic [7:0] r;
        r = qalu(a, b, op);
`ifdef QALU_ARB_OPCHECK_EN
        e = !legal(int'(a), int'(b), int'(op));
`else
        e = 1'b0;
`endif
        d = e ? 7'd0 : r[6:0];
        c = !e && op == 4'd0 && r[7];
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Drives one transaction on requester n and reports what was observed.
    task automatic issue(input int n, input logic [6:0] a, input logic [6:0] b, input logic [3:0] op,
                         input int hold, input bit poke,
                         output logic [6:0] d, output logic c, output logic e,
                         output int w, output int lat, output bit stable);
        @(negedge clk);
        if (n == 0) begin req0_valid = 1; req0_a = a; req0_b = b; req0_op = op; end
        else begin req1_valid = 1; req1_a = a; req1_b = b; req1_op = op; end
        #1;
        w = 0;
        while (!(n == 0 ? req0_ready : req1_ready) && w < 20) begin step(); w++; end
        step();
        if (n == 0) req0_valid = 0; else req1_valid = 0;
        lat = 1;
        while ((n == 0 ? resp0_valid : resp1_valid) !== 1'b1 && lat < 20) begin step(); lat++; end
        d = n == 0 ? resp0_data : resp1_data;
        c = n == 0 ? resp0_carry : resp1_carry;
        e = n == 0 ? resp0_err : resp1_err;
        stable = (n == 0 ? resp1_valid : resp0_valid) === 1'b0;
        for (int i = 0; i < hold; i++) begin
            if (poke) begin if (n == 0) req1_valid = 1; else req0_valid = 1; end
            #1;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0) stable = 0;
            step();
            if ((n == 0 ? {resp0_valid, resp0_data, resp0_carry, resp0_err}
                        : {resp1_valid, resp1_data, resp1_carry, resp1_err}) !== {1'b1, d, c, e}) stable = 0;
        end
        if (poke) begin if (n == 0) req1_valid = 0; else req0_valid = 0; end
        if (n == 0) resp0_ready = 1; else resp1_ready = 1;
        step();
        if (n == 0) resp0_ready = 0; else resp1_ready = 0;
        if ((n == 0 ? resp0_valid : resp1_valid) !== 1'b0) stable = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        req0_valid = 1; req1_valid = 1;
        step();
        step();
        total++;
        if ({req0_ready, req1_ready, resp0_valid, resp1_valid} !== 4'b0)
            $display("FAIL reset_handshake got %b want 0000", {req0_ready, req1_ready, resp0_valid, resp1_valid});
        else passed++;
        total++;
        if ({alu_a, alu_b, alu_sel} !== 18'd0)
            $display("FAIL reset_alu got a=%0d b=%0d sel=%0d want 0", alu_a, alu_b, alu_sel);
        else passed++;
        total++;
        if ({resp0_data, resp0_carry, resp0_err, resp1_data, resp1_carry, resp1_err} !== 18'd0)
            $display("FAIL reset_resp got d0=%0d d1=%0d want 0", resp0_data, resp1_data);
        else passed++;
        req0_valid = 0; req1_valid = 0;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_vectors();
        logic [6:0] d;
        logic c, e;
        int w, lat;
        bit s;
        issue(0, 7'd13, 7'd12, 4'd0, 0, 0, d, c, e, w, lat, s);
        total++;
        if ({d, c, e} !== {7'd31, 2'b00}) $display("FAIL add_13_12 got d=%0d c=%b e=%b want 31 0 0", d, c, e);
        else passed++;
        total++;
        if (lat !== 2 || w !== 0) $display("FAIL latency got lat=%0d wait=%0d want 2 0", lat, w);
        else passed++;
        issue(1, 7'd33, 7'd1, 4'd0, 0, 0, d, c, e, w, lat, s);
        total++;
        if ({d, c, e} !== {7'd0, 2'b10}) $display("FAIL add_33_01 got d=%0d c=%b e=%b want 0 1 0", d, c, e);
        else passed++;
        issue(1, 7'd32, 7'd13, 4'd1, 0, 0, d, c, e, w, lat, s);
        total++;
        if ({d, c, e} !== {7'd13, 2'b00}) $display("FAIL sub_32_13 got d=%0d c=%b e=%b want 13 0 0", d, c, e);
        else passed++;
        issue(0, 7'd1, 7'd2, 4'd1, 0, 0, d, c, e, w, lat, s);
        total++;
        if ({d, c, e} !== {7'd33, 2'b00}) $display("FAIL sub_borrow_masked got d=%0d c=%b e=%b want 33 0 0", d, c, e);
        else passed++;
    endtask

    task automatic test_contention();
        int grants[$];
        int when[$];
        int rv0, rv1;
        bit both;
        rst = 1;
        step();
        rst = 0;
        rv0 = 0; rv1 = 0; both = 0;
        req0_a = 7'd1; req0_b = 7'd2; req0_op = 4'd0;
        req1_a = 7'd3; req1_b = 7'd1; req1_op = 4'd0;
        req0_valid = 1; req1_valid = 1; resp0_ready = 1; resp1_ready = 1;
        for (int k = 0; k < 30; k++) begin
            #1;
            if (req0_ready && req1_ready) both = 1;
            if (req0_ready) begin grants.push_back(0); when.push_back(k); end
            if (req1_ready) begin grants.push_back(1); when.push_back(k); end
            if (resp0_valid) rv0++;
            if (resp1_valid) rv1++;
            @(negedge clk);
        end
        req0_valid = 0; req1_valid = 0;
        step();
        resp0_ready = 0; resp1_ready = 0;
        total++;
        if (both) $display("FAIL contention_both_ready got 1 want 0");
        else passed++;
        total++;
        if (grants.size() !== 10) $display("FAIL contention_grant_count got %0d want 10", grants.size());
        else passed++;
        for (int i = 0; i < grants.size(); i++) begin
            total++;
            if (grants[i] !== i % 2) $display("FAIL contention_order grant %0d got req%0d want req%0d", i, grants[i], i % 2);
            else passed++;
            if (i > 0) begin
                total++;
                if (when[i] - when[i-1] !== 3) $display("FAIL contention_spacing grant %0d got %0d want 3", i, when[i] - when[i-1]);
                else passed++;
            end
        end
        total++;
        if (rv0 !== 5 || rv1 !== 5) $display("FAIL single_consume got %0d/%0d want 5/5", rv0, rv1);
        else passed++;
    endtask

    task automatic test_backpressure();
        logic [6:0] d;
        logic c, e;
        int w, lat;
        bit s;
        issue(0, 7'd2, 7'd3, 4'd0, 5, 1, d, c, e, w, lat, s);
        total++;
        if (s !== 1'b1) $display("FAIL backpressure_stable got 0 want 1");
        else passed++;
        total++;
        if ({d, c, e} !== {7'd11, 2'b00}) $display("FAIL backpressure_data got d=%0d c=%b e=%b want 11 0 0", d, c, e);
        else passed++;
    endtask

    task automatic test_opcheck();
        logic [6:0] d, xd;
        logic c, e, xe;
        int w, lat;
        bit s;
`ifdef QALU_ARB_OPCHECK_EN
        xd = 7'd0; xe = 1'b1;
`else
        xd = 7'd21; xe = 1'b0;
`endif
        issue(0, 7'd14, 7'd1, 4'd0, 0, 0, d, c, e, w, lat, s);
        total++;
        if ({d, c, e} !== {xd, 1'b0, xe}) $display("FAIL opcheck_digit got d=%0d c=%b e=%b want %0d 0 %b", d, c, e, xd, xe);
        else passed++;
        total++;
        if (lat !== 2) $display("FAIL opcheck_latency got %0d want 2", lat);
        else passed++;
        issue(1, 7'd1, 7'd1, 4'd5, 0, 0, d, c, e, w, lat, s);
        total++;
        if ({d, c, e} !== {7'd0, 1'b0, xe}) $display("FAIL opcheck_op got d=%0d c=%b e=%b want 0 0 %b", d, c, e, xe);
        else passed++;
        issue(1, 7'd30, 7'd3, 4'd4, 0, 0, d, c, e, w, lat, s);
        total++;
        if ({d, c, e} !== {7'd1, 2'b00}) $display("FAIL opcheck_legal got d=%0d c=%b e=%b want 1 0 0", d, c, e);
        else passed++;
    endtask

    task automatic test_random();
        logic [6:0] a, b, d, xd;
        logic [3:0] op;
        logic c, e, xc, xe;
        int n, hold, w, lat;
        bit s;
        for (int t = 0; t < 40; t++) begin
            n = int'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) begin
                a = 7'($urandom_range(0, 99));
                b = 7'($urandom_range(0, 99));
                op = 4'($urandom_range(0, 7));
            end else begin
                a = 7'($urandom_range(0, 3) * 10 + $urandom_range(0, 3));
                b = 7'($urandom_range(0, 3) * 10 + $urandom_range(0, 3));
                op = 4'($urandom_range(0, 4));
            end
            hold = int'($urandom_range(0, 2));
            model(a, b, op, xd, xc, xe);
            issue(n, a, b, op, hold, 0, d, c, e, w, lat, s);
            total++;
            if ({d, c, e} !== {xd, xc, xe})
                $display("FAIL random_result t=%0d req%0d a=%0d b=%0d op=%0d got %0d %b %b want %0d %b %b",
                         t, n, a, b, op, d, c, e, xd, xc, xe);
            else passed++;
            total++;
            if (lat !== 2 || w !== 0) $display("FAIL random_timing t=%0d got lat=%0d wait=%0d want 2 0", t, lat, w);
            else passed++;
            total++;
            if (s !== 1'b1) $display("FAIL random_handshake t=%0d got unstable want stable", t);
            else passed++;
        end
    endtask

    task automatic test_reset_exec();
        logic [6:0] d;
        logic c, e;
        int w, lat;
        bit s, seen;
        @(negedge clk);
        req0_valid = 1; req0_a = 7'd21; req0_b = 7'd3; req0_op = 4'd1;
        #1;
        w = 0;
        while (!req0_ready && w < 20) begin step(); w++; end
        step();
        req0_valid = 0;
        req1_valid = 1;
        rst = 1;
        #1;
        total++;
        if ({req0_ready, req1_ready, resp0_valid, resp1_valid} !== 4'b0)
            $display("FAIL reset_exec_handshake got %b want 0000", {req0_ready, req1_ready, resp0_valid, resp1_valid});
        else passed++;
        total++;
        if ({alu_a, alu_b, alu_sel, resp0_data} !== 25'd0)
            $display("FAIL reset_exec_regs got a=%0d b=%0d sel=%0d d=%0d want 0", alu_a, alu_b, alu_sel, resp0_data);
        else passed++;
        req1_valid = 0;
        step();
        rst = 0;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0) seen = 1;
        end
        total++;
        if (seen) $display("FAIL reset_exec_discard got resp want none");
        else passed++;
        issue(0, 7'd21, 7'd3, 4'd1, 0, 0, d, c, e, w, lat, s);
        total++;
        if ({d, c, e} !== {7'd12, 2'b00} || lat !== 2) $display("FAIL reset_exec_reissue got d=%0d c=%b e=%b lat=%0d want 12 0 0 2", d, c, e, lat);
        else passed++;
    endtask

    initial begin
        rst = 1;
        req0_valid = 0; req1_valid = 0; resp0_ready = 0; resp1_ready = 0;
        req0_a = 0; req0_b = 0; req0_op = 0; req1_a = 0; req1_b = 0; req1_op = 0;
        test_reset();
        test_vectors();
        test_contention();
        test_backpressure();
        test_opcheck();
        test_random();
        test_reset_exec();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
